// File: rtl/msk_refresh_scheduler_pkg.sv
// Shared definitions for the masked-word refresh scheduler.
// Holds the FSM state encoding plus the slice/counter sizing helpers
// used by the top and the refresh datapath.
package msk_refresh_scheduler_pkg;

   // IDLE: waiting for a word; REFRESH: one chunk per rnd beat; OUT: word held for consumer
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REFRESH = 2'd1,
      ST_OUT     = 2'd2
   } state_e;

   // Width of one chunk in the buffer: BITS bits, each carried as d shares
   function automatic int slice_w(input int d, input int bits);
      return d * bits;
   endfunction

   // Chunk counter width; a single-chunk word still needs a 1-bit counter
   function automatic int cnt_w(input int chunks);
      return (chunks > 1) ? $clog2(chunks) : 1;
   endfunction

endpackage

// File: rtl/msk_refresh_scheduler_tree.sv
// Refresh datapath (MSKrefresh_tree): re-randomises one BITS-bit chunk of a d-share word.
// Ports: x_i = chunk in (bit i shares at [i*d +: d]), rnd_i = (d-1)*BITS fresh random bits,
//        y_o = refreshed chunk, same layout. Purely combinational.
module msk_refresh_scheduler_tree
   import msk_refresh_scheduler_pkg::*;
#(
   parameter int d    = 2,
   parameter int BITS = 16
) (
   input  logic [d*BITS-1:0]     x_i,
   input  logic [(d-1)*BITS-1:0] rnd_i,
   output logic [d*BITS-1:0]     y_o
);

   localparam int SW = slice_w(d, BITS);

   logic [SW-1:0] y;

   // Share j<d-1 of bit i takes random word j; the last share absorbs the XOR of
   // all of them, so the XOR over shares of every bit is left unchanged.
   for (genvar i = 0; i < BITS; i++) begin : g_bit
      logic [d-2:0] rv;
      for (genvar j = 0; j < d - 1; j++) begin : g_rnd
         assign rv[j] = rnd_i[j*BITS + i];
      end
      assign y[i*d +: d-1]   = x_i[i*d +: d-1] ^ rv;
      assign y[i*d + d - 1]  = x_i[i*d + d - 1] ^ (^rv);
   end

   assign y_o = y;

endmodule

// File: rtl/msk_refresh_scheduler.sv
// Chunk-serial refresh scheduler: takes a d-share word, refreshes CHUNKS chunks of BITS bits
// through one shared refresh datapath (one chunk per accepted rnd beat), then presents the word.
// Ports: in_* word input (valid/ready), rnd_* randomness (valid/ready), out_* word output, busy.
module msk_refresh_scheduler
   import msk_refresh_scheduler_pkg::*;
#(
   parameter int d      = 2,
   parameter int BITS   = 16,
   parameter int CHUNKS = 8
) (
   input  logic                       clk,
   input  logic                       syn_rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [d*CHUNKS*BITS-1:0]   in_data,
   input  logic                       rnd_valid,
   output logic                       rnd_ready,
   input  logic [(d-1)*BITS-1:0]      rnd_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [d*CHUNKS*BITS-1:0]   out_data,
   output logic                       busy
);

   localparam int W  = CHUNKS * BITS;
   localparam int SW = slice_w(d, BITS);
   localparam int CW = cnt_w(CHUNKS);

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [d*W-1:0]  buf_q;
   logic [d*W-1:0]  buf_d;
   logic            in_ready_q;
   logic            rnd_ready_q;
   logic            out_valid_q;
   logic            busy_q;

   logic [SW-1:0]   slice_cur;
   logic [SW-1:0]   slice_ref;
   logic            last_chunk;

   assign slice_cur  = buf_q[int'(cnt_q)*SW +: SW];
   assign last_chunk = (cnt_q == CW'(CHUNKS - 1));

   msk_refresh_scheduler_tree #(
      .d    (d),
      .BITS (BITS)
   ) u_refresh_tree (
      .x_i   (slice_cur),
      .rnd_i (rnd_data),
      .y_o   (slice_ref)
   );

   // Write-back mux: only the slice under the counter is replaced
   always_comb begin
      buf_d = buf_q;
      buf_d[int'(cnt_q)*SW +: SW] = slice_ref;
   end

   // The refreshed chunk only becomes visible through buf_q, never straight from the datapath
   always_ff @(posedge clk) begin
      if (syn_rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         buf_q       <= '0;
         in_ready_q  <= 1'b1;
         rnd_ready_q <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  buf_q       <= in_data;
                  cnt_q       <= '0;
                  state_q     <= ST_REFRESH;
                  in_ready_q  <= 1'b0;
                  rnd_ready_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            ST_REFRESH: begin
               // rnd_valid low is a stall: nothing moves, no randomness consumed
               if (rnd_valid) begin
                  buf_q <= buf_d;
                  if (last_chunk) begin
                     cnt_q       <= '0;
                     state_q     <= ST_OUT;
                     rnd_ready_q <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               cnt_q       <= '0;
               in_ready_q  <= 1'b1;
               rnd_ready_q <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   // Handshake outputs are forced low in the reset cycle itself, before the registers clear
   assign in_ready  = in_ready_q  & ~syn_rst;
   assign rnd_ready = rnd_ready_q & ~syn_rst;
   assign out_valid = out_valid_q & ~syn_rst;
   assign busy      = busy_q      & ~syn_rst;
   assign out_data  = buf_q;

endmodule

// File: tb/tb_msk_refresh_scheduler.sv
module tb_msk_refresh_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- DUT A: d=2, BITS=4, CHUNKS=2 ----------------
   logic        a_syn_rst, a_in_valid, a_in_ready, a_rnd_valid, a_rnd_ready;
   logic        a_out_valid, a_out_ready, a_busy;
   logic [15:0] a_in_data, a_out_data;
   logic [3:0]  a_rnd_data;

   msk_refresh_scheduler #(.d(2), .BITS(4), .CHUNKS(2)) dut_a (
      .clk(clk), .syn_rst(a_syn_rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready), .rnd_data(a_rnd_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .busy(a_busy)
   );

   // ---------------- DUT B: d=3, BITS=16, CHUNKS=8 ----------------
   logic         b_syn_rst, b_in_valid, b_in_ready, b_rnd_valid, b_rnd_ready;
   logic         b_out_valid, b_out_ready, b_busy;
   logic [383:0] b_in_data, b_out_data;
   logic [31:0]  b_rnd_data;

   msk_refresh_scheduler #(.d(3), .BITS(16), .CHUNKS(8)) dut_b (
      .clk(clk), .syn_rst(b_syn_rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready), .rnd_data(b_rnd_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .busy(b_busy)
   );

   function automatic logic [127:0] unmask3(input logic [383:0] x);
      logic [127:0] u;
      for (int i = 0; i < 128; i++) u[i] = x[i*3] ^ x[i*3+1] ^ x[i*3+2];
      return u;
   endfunction

   // ---------------- scoreboards ----------------
   typedef struct { logic [15:0] data; int lat; } a_exp_t;
   a_exp_t       exp_a[$];
   logic [127:0] exp_b[$];

   int a_outs = 0, a_hs_cyc = 0, a_rnd_cnt = 0;
   logic a_prev_ov = 1'b0;

   always @(negedge clk) begin
      if (a_syn_rst) begin
         a_rnd_cnt = 0;
         a_prev_ov = 1'b0;
      end else begin
         if (a_in_valid && a_in_ready) a_hs_cyc = cyc;
         if (a_rnd_valid && a_rnd_ready) a_rnd_cnt++;
         if (a_out_valid && !a_prev_ov) begin
            if (exp_a.size() == 0) begin
               total++; bad++;
               $display("FAIL a_unexpected_out actual=%0h required=none", a_out_data);
            end else begin
               chk("a_latency", 128'(cyc - a_hs_cyc), 128'(exp_a[0].lat));
            end
         end
         if (a_out_valid && a_out_ready && exp_a.size() != 0) begin
            a_exp_t e;
            e = exp_a.pop_front();
            chk("a_out_data", 128'(a_out_data), 128'(e.data));
            chk("a_rnd_beats", 128'(a_rnd_cnt), 128'd2);
            a_rnd_cnt = 0;
            a_outs++;
         end
         a_prev_ov = a_out_valid;
      end
   end

   int b_outs = 0, b_rnd_cnt = 0;
   logic         b_prev_stall = 1'b0;
   logic [383:0] b_prev_data;

   always @(negedge clk) begin
      if (b_syn_rst) begin
         b_rnd_cnt    = 0;
         b_prev_stall = 1'b0;
      end else begin
         if (b_rnd_valid && b_rnd_ready) b_rnd_cnt++;
         if (b_prev_stall) begin
            chk("b_hold_vld", 128'(b_out_valid), 128'd1);
            chk("b_hold_dat", 128'(b_out_data == b_prev_data), 128'd1);
         end
         if (b_out_valid && b_out_ready) begin
            if (exp_b.size() == 0) begin
               total++; bad++;
               $display("FAIL b_unexpected_out actual=%0h required=none", unmask3(b_out_data));
            end else begin
               chk("b_unmasked", unmask3(b_out_data), exp_b.pop_front());
               chk("b_rnd_beats", 128'(b_rnd_cnt), 128'd8);
            end
            b_rnd_cnt = 0;
            b_outs++;
         end
         b_prev_stall = b_out_valid && !b_out_ready;
         b_prev_data  = b_out_data;
      end
   end

   // ---------------- DUT A stimulus helpers ----------------
   // Called at a drive point (just after a posedge) with DUT A idle; returns just after
   // the edge that consumed the last chunk.
   task automatic send_a(input logic [15:0] din, input logic [3:0] r0, input logic [3:0] r1,
                         input int stall, input logic [15:0] exp);
      a_exp_t e;
      e.data = exp;
      e.lat  = 3 + stall;
      exp_a.push_back(e);
      a_in_data   = din;
      a_in_valid  = 1'b1;
      a_rnd_data  = r0;
      a_rnd_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      a_in_data  = 16'hDEAD;
      @(posedge clk); #1;
      if (stall > 0) begin
         a_rnd_valid = 1'b0;
         a_rnd_data  = 4'h9;
         repeat (stall) @(posedge clk);
         #1;
      end
      a_rnd_data  = r1;
      a_rnd_valid = 1'b1;
      @(posedge clk); #1;
      a_rnd_valid = 1'b0;
      a_rnd_data  = 4'h0;
   endtask

   task automatic wait_a_outs(input int n);
      int t = 0;
      while (a_outs < n && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (a_outs < n) begin
         total++; bad++;
         $display("FAIL a_timeout actual=%0d required=%0d", a_outs, n);
      end
   endtask

   // ---------------- DUT B random drivers ----------------
   initial begin
      b_rnd_valid = 1'b0; b_rnd_data = '0; b_out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         b_rnd_valid = ($urandom_range(0, 3) != 0);
         b_rnd_data  = $urandom;
         b_out_ready = ($urandom_range(0, 2) != 0);
      end
   end

   task automatic b_stim();
      logic [383:0] bd;
      for (int w = 0; w < 1000; w++) begin
         int t = 0;
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         for (int k = 0; k < 12; k++) bd[k*32 +: 32] = $urandom;
         b_in_data  = bd;
         b_in_valid = 1'b1;
         @(negedge clk);
         while (!b_in_ready && t < 1000) begin
            @(negedge clk);
            t++;
         end
         if (!b_in_ready) begin
            total++; bad++;
            $display("FAIL b_in_timeout actual=%0d required=1", b_in_ready);
         end else begin
            exp_b.push_back(unmask3(bd));
         end
         @(posedge clk); #1;
         b_in_valid = 1'b0;
         for (int k = 0; k < 12; k++) b_in_data[k*32 +: 32] = $urandom;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int t;
      a_syn_rst = 1'b1; a_in_valid = 1'b0; a_in_data = '0;
      a_rnd_valid = 1'b0; a_rnd_data = '0; a_out_ready = 1'b1;
      b_syn_rst = 1'b1; b_in_valid = 1'b0; b_in_data = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 128'(a_in_ready), 128'd0);
      chk("rst_out_valid", 128'(a_out_valid), 128'd0);
      chk("rst_rnd_ready", 128'(a_rnd_ready), 128'd0);
      chk("rst_busy", 128'(a_busy), 128'd0);
      @(posedge clk); #1;
      a_syn_rst = 1'b0;
      b_syn_rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 128'(a_in_ready), 128'd1);
      chk("post_rst_busy", 128'(a_busy), 128'd0);
      chk("post_rst_rnd_ready", 128'(a_rnd_ready), 128'd0);
      chk("post_rst_out_valid", 128'(a_out_valid), 128'd0);
      chk("post_rst_out_data", 128'(a_out_data), 128'd0);
      @(posedge clk); #1;

      fork b_stim(); join_none

      // identity: zero randomness leaves every share untouched
      send_a(16'hA5C3, 4'h0, 4'h0, 0, 16'hA5C3);
      wait_a_outs(1);
      // all-ones randomness flips both shares of every bit
      send_a(16'hA5C3, 4'hF, 4'hF, 0, 16'h5A3C);
      wait_a_outs(2);
      // only chunk 0 (low byte) flipped
      send_a(16'hA5C3, 4'hF, 4'h0, 0, 16'hA53C);
      wait_a_outs(3);
      // randomness stall of 5 cycles after chunk 0
      send_a(16'hA5C3, 4'hF, 4'hF, 5, 16'h5A3C);
      wait_a_outs(4);

      // output backpressure for 4 cycles
      a_out_ready = 1'b0;
      send_a(16'h1234, 4'h0, 4'h0, 0, 16'h1234);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 128'(a_out_valid), 128'd1);
         chk("bp_in_ready", 128'(a_in_ready), 128'd0);
         chk("bp_out_data", 128'(a_out_data), 128'h1234);
      end
      @(posedge clk); #1;
      a_out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_idle_busy", 128'(a_busy), 128'd0);
      chk("bp_idle_in_ready", 128'(a_in_ready), 128'd1);
      wait_a_outs(5);

      // reset during chunk 1: word is dropped
      a_in_data   = 16'hBEEF;
      a_in_valid  = 1'b1;
      a_rnd_data  = 4'hF;
      a_rnd_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      @(posedge clk); #1;
      a_syn_rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", 128'(a_in_ready), 128'd0);
      @(posedge clk); #1;
      a_syn_rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", 128'(a_busy), 128'd0);
      chk("mid_rst_out_valid", 128'(a_out_valid), 128'd0);
      chk("mid_rst_rnd_ready", 128'(a_rnd_ready), 128'd0);
      chk("mid_rst_buffer", 128'(a_out_data), 128'd0);
      chk("mid_rst_in_ready_after", 128'(a_in_ready), 128'd1);
      @(posedge clk); #1;
      a_rnd_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("mid_rst_no_output", 128'(a_outs), 128'd5);

      // next word after the abort processes normally
      send_a(16'h0F0F, 4'hF, 4'hF, 0, 16'hF0F0);
      wait_a_outs(6);

      t = 0;
      while (b_outs < 1000 && t < 80000) begin
         @(posedge clk);
         t++;
      end
      chk("b_words_done", 128'(b_outs), 128'd1000);
      chk("a_queue_empty", 128'(exp_a.size()), 128'd0);
      chk("b_queue_empty", 128'(exp_b.size()), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/msk_refresh_scheduler.md
Name: msk_refresh_scheduler

Overview:
- Sequences one narrow refresh datapath over a wide masked word, chunk by chunk.
- Accepts a d-share word of CHUNKS*BITS bits. Refreshes one BITS-bit chunk per cycle in which fresh randomness is available. Presents the fully refreshed word on a valid/ready output.
- Sits between a masked state register and its consumer (e.g. key or state re-masking between AES blocks). Shares a single MSKrefresh_tree instance across all chunks and arbitrates randomness from the PRNG.

Parameters:
- d, 2, number of shares (>=2)
- BITS, 16, bits refreshed per cycle (chunk width)
- CHUNKS, 8, chunks per word (>=1); word width W = CHUNKS*BITS bits, d*W wires

Ports:
- clk  in  1  clock
- syn_rst  in  1  synchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  scheduler accepts input
- in_data  in  d*W  masked input word; bit i shares at [i*d +: d]
- rnd_valid  in  1  randomness valid
- rnd_ready  out  1  randomness consumed this cycle (when rnd_valid)
- rnd_data  in  (d-1)*BITS  fresh randomness for one chunk
- out_valid  out  1  refreshed word valid
- out_ready  in  1  consumer accepts output
- out_data  out  d*W  refreshed masked word, same layout as in_data
- busy  out  1  state != IDLE

Behaviour:
- Clock, reset and state:
  - Single clock clk; reset syn_rst is synchronous and active-high.
  - On reset: state=IDLE, chunk counter cnt=0, data buffer cleared to all-zero.
  - Outputs during and immediately after reset: out_valid=0, rnd_ready=0, busy=0. in_ready=0 while syn_rst=1, otherwise 1 in IDLE.
  - Reset mid-operation aborts the word: the buffer is zeroed and no output is produced.
- Chunk slicing:
  - Chunk c occupies buffer bits [c*BITS*d +: BITS*d].
  - cnt has width max(1, clog2(CHUNKS)).
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid & in_ready: buffer <= in_data, cnt <= 0, go REFRESH.
  - REFRESH:
    - rnd_ready=1; it depends on state only, never on rnd_valid.
    - The datapath refreshes chunk cnt with rnd_data.
    - On rnd_valid: the refreshed chunk is written back into the buffer at slice cnt.
      - If cnt==CHUNKS-1, go OUT and reset cnt to 0.
      - Otherwise cnt <= cnt+1.
    - rnd_valid=0 is a stall: buffer and cnt unchanged, no randomness consumed.
  - OUT:
    - out_valid=1, out_data=buffer (registered, stable while out_valid & ~out_ready).
    - On out_ready: go IDLE.
    - in_ready=0 in OUT; no overlap between words.
- Latency and throughput:
  - Input handshake at cycle t, with rnd_valid held high: out_valid rises at t+CHUNKS+1.
  - Minimum period is CHUNKS+2 cycles per word.
- Masking and ordering rules:
  - Every chunk is refreshed with randomness from a distinct rnd handshake; rnd_data is never reused across chunks.
  - The refreshed chunk is registered before being observable; out_data is never driven by combinational datapath output.
  - The unmasked value (XOR over shares per bit) of out_data equals that of in_data.
  - CHUNKS=1: REFRESH lasts exactly one accepted rnd beat.
- in_data and rnd_data are ignored when their valid/ready handshakes do not fire.

Decomposition:
- Shared package:
  - state encoding (IDLE, REFRESH, OUT)
  - chunk slice width constant BITS*d
  - cnt width function max(1, clog2(CHUNKS))
- Sub-module: one MSKrefresh_tree instance (d, BITS) as the refresh datapath.
  - Input: the buffer slice selected by cnt.
  - rnd: rnd_data.
  - Output: feeds the write-back mux.
- No other sub-module; mux and FSM are local.

Test Plan:
- Identity and latency:
  - Stimulus: d=2, BITS=4, CHUNKS=2, in_data=16'hA5C3, rnd_data=0 held valid, out_ready=1.
  - Required: out_data=16'hA5C3, out_valid exactly 3 cycles after the input handshake, rnd handshakes=2.
- All-ones randomness:
  - Stimulus: same config, rnd_data=4'hF on every beat.
  - Required: out_data=~16'hA5C3=16'h5A3C (both shares of every bit flip); unmasked value unchanged.
- Randomness stall:
  - Stimulus: rnd_valid low for 5 cycles mid-REFRESH (after chunk 0).
  - Required: cnt and buffer frozen; out_valid delayed exactly 5 cycles; output equals the unstalled result.
- Output backpressure:
  - Stimulus: out_ready=0 for 4 cycles.
  - Required: out_valid held, out_data stable; in_ready=0 throughout; IDLE one cycle after out_ready=1.
- Reset mid-REFRESH:
  - Stimulus: assert syn_rst for 1 cycle during chunk 1.
  - Required: next cycle state=IDLE, out_valid=0, rnd_ready=0, busy=0; buffer all-zero; next word processes normally.
- Random regression:
  - Stimulus: d=3, BITS=16, CHUNKS=8, random valid/ready patterns, 1000 words.
  - Required: per-word unmasked value preserved; exactly 8 rnd beats per word; no rnd beat consumed outside REFRESH.
